// File: rtl/afu_tx_ab_commit_arb.sv
// -----------------------------------------------------------------------------
// afu_tx_ab_commit_arb
//
// Per-port TX merge stage. Arbitrates AFU TX A (all TLPs) and TX B
// (reads/interrupts) at packet granularity into a single TX stream using a
// round-robin preference that flips on every start-of-packet. Every memory
// write accepted from TX A queues its tag in a small FIFO, and a one-beat
// local write-commit completion is emitted on the RX B commit stream after
// the write's last beat has been accepted downstream.
//
// Ports:
//   clk, rst_n           port clock, asynchronous active-low reset
//   tx_a_*               TX A AXI-S source (tvalid/tready/tdata/tkeep/tlast/tuser)
//   tx_b_*               TX B AXI-S source (same widths as TX A)
//   out_*                merged TX AXI-S stream towards the PF/VF mux
//   commit_*             RX B write-commit stream (one beat per write)
// -----------------------------------------------------------------------------
module afu_tx_ab_commit_arb #(
   parameter int unsigned TDATA_WIDTH  = 512,
   parameter int unsigned TUSER_WIDTH  = 10,
   parameter int unsigned COMMIT_DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,

   input  logic                     tx_a_tvalid,
   output logic                     tx_a_tready,
   input  logic [TDATA_WIDTH-1:0]   tx_a_tdata,
   input  logic [TDATA_WIDTH/8-1:0] tx_a_tkeep,
   input  logic                     tx_a_tlast,
   input  logic [TUSER_WIDTH-1:0]   tx_a_tuser,

   input  logic                     tx_b_tvalid,
   output logic                     tx_b_tready,
   input  logic [TDATA_WIDTH-1:0]   tx_b_tdata,
   input  logic [TDATA_WIDTH/8-1:0] tx_b_tkeep,
   input  logic                     tx_b_tlast,
   input  logic [TUSER_WIDTH-1:0]   tx_b_tuser,

   output logic                     out_tvalid,
   input  logic                     out_tready,
   output logic [TDATA_WIDTH-1:0]   out_tdata,
   output logic [TDATA_WIDTH/8-1:0] out_tkeep,
   output logic                     out_tlast,
   output logic [TUSER_WIDTH-1:0]   out_tuser,

   output logic                     commit_tvalid,
   input  logic                     commit_tready,
   output logic [TDATA_WIDTH-1:0]   commit_tdata,
   output logic [TDATA_WIDTH/8-1:0] commit_tkeep,
   output logic                     commit_tlast
);

   localparam int unsigned AW = $clog2(COMMIT_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(COMMIT_DEPTH);

   typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;
   typedef enum logic {SRC_A, SRC_B} src_t;

   state_t state_q, state_d;
   src_t   rr_q, rr_d;

   logic sel_a, sel_b;
   logic a_elig, b_elig;
   logic a_hs, out_hs, in_idle;

   logic          sop_is_wr;
   logic [9:0]    sop_tag;
   logic          wr_q;
   logic [9:0]    tag_q;
   logic          push, pop;
   logic [9:0]    push_tag;

   logic [9:0]    mem [COMMIT_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [9:0]    head_tag;

   assign in_idle = (state_q == IDLE);

   // Arbitration, output mux and next-state. Eligibility is gated by rst_n so
   // that every output sits at its idle value while reset is held.
   always_comb begin
      sel_a   = 1'b0;
      sel_b   = 1'b0;
      state_d = state_q;
      rr_d    = rr_q;
      a_elig  = rst_n && tx_a_tvalid && (count_q < DEPTH_C);
      b_elig  = rst_n && tx_b_tvalid;

      case (state_q)
         IDLE: begin
            if (a_elig && (!b_elig || rr_q == SRC_A)) sel_a = 1'b1;
            else if (b_elig)                          sel_b = 1'b1;
         end
         LOCK_A:  sel_a = 1'b1;
         LOCK_B:  sel_b = 1'b1;
         default: ;
      endcase

      out_tvalid  = (sel_a && tx_a_tvalid) || (sel_b && tx_b_tvalid);
      out_tdata   = sel_b ? tx_b_tdata : tx_a_tdata;
      out_tkeep   = sel_b ? tx_b_tkeep : tx_a_tkeep;
      out_tlast   = sel_b ? tx_b_tlast : tx_a_tlast;
      out_tuser   = sel_b ? tx_b_tuser : tx_a_tuser;
      tx_a_tready = sel_a && out_tready;
      tx_b_tready = sel_b && out_tready;
      out_hs      = out_tvalid && out_tready;

      if (out_hs) begin
         case (state_q)
            IDLE: begin
               rr_d = sel_a ? SRC_B : SRC_A;
               if (!out_tlast) state_d = sel_a ? LOCK_A : LOCK_B;
            end
            LOCK_A, LOCK_B: if (out_tlast) state_d = IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= SRC_A;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
      end
   end

   // Write tracking: the header is only on the SOP beat, so its write flag
   // and tag are held for the tlast beat; a single-beat write uses its own
   // header directly.
   assign a_hs      = tx_a_tready && tx_a_tvalid;
   assign sop_is_wr = (tx_a_tdata[31:24] == 8'h40) || (tx_a_tdata[31:24] == 8'h60);
   assign sop_tag   = {tx_a_tdata[23], tx_a_tdata[19], tx_a_tdata[47:40]};
   assign push_tag  = in_idle ? sop_tag : tag_q;
   assign push      = a_hs && tx_a_tlast && (in_idle ? sop_is_wr : wr_q);
   assign pop       = commit_tvalid && commit_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= 1'b0;
         tag_q <= '0;
      end else if (a_hs && in_idle) begin
         wr_q  <= sop_is_wr;
         tag_q <= sop_tag;
      end
   end

   // Commit FIFO
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= push_tag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_tag      = mem[rd_ptr_q];
   assign commit_tvalid = (count_q != '0);
   assign commit_tlast  = 1'b1;

   always_comb begin
      commit_tdata        = '0;
      commit_tdata[31:24] = 8'h0A;
      commit_tdata[23]    = head_tag[9];
      commit_tdata[19]    = head_tag[8];
      commit_tdata[79:72] = head_tag[7:0];
      commit_tkeep        = '0;
      commit_tkeep[31:0]  = '1;
   end

endmodule

// File: tb/tb_afu_tx_ab_commit_arb.sv
module tb_afu_tx_ab_commit_arb;

   localparam int unsigned TDW   = 512;
   localparam int unsigned TUW   = 10;
   localparam int unsigned DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             tx_a_tvalid, tx_a_tready, tx_a_tlast;
   logic [TDW-1:0]   tx_a_tdata;
   logic [TDW/8-1:0] tx_a_tkeep;
   logic [TUW-1:0]   tx_a_tuser;
   logic             tx_b_tvalid, tx_b_tready, tx_b_tlast;
   logic [TDW-1:0]   tx_b_tdata;
   logic [TDW/8-1:0] tx_b_tkeep;
   logic [TUW-1:0]   tx_b_tuser;
   logic             out_tvalid, out_tready, out_tlast;
   logic [TDW-1:0]   out_tdata;
   logic [TDW/8-1:0] out_tkeep;
   logic [TUW-1:0]   out_tuser;
   logic             commit_tvalid, commit_tready, commit_tlast;
   logic [TDW-1:0]   commit_tdata;
   logic [TDW/8-1:0] commit_tkeep;

   int checks = 0;
   int errors = 0;

   logic [16:0] out_q[$];
   logic [79:0] commit_q[$];

   always #5 clk = ~clk;

   afu_tx_ab_commit_arb #(
      .TDATA_WIDTH (TDW),
      .TUSER_WIDTH (TUW),
      .COMMIT_DEPTH(DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_a_tvalid  (tx_a_tvalid),
      .tx_a_tready  (tx_a_tready),
      .tx_a_tdata   (tx_a_tdata),
      .tx_a_tkeep   (tx_a_tkeep),
      .tx_a_tlast   (tx_a_tlast),
      .tx_a_tuser   (tx_a_tuser),
      .tx_b_tvalid  (tx_b_tvalid),
      .tx_b_tready  (tx_b_tready),
      .tx_b_tdata   (tx_b_tdata),
      .tx_b_tkeep   (tx_b_tkeep),
      .tx_b_tlast   (tx_b_tlast),
      .tx_b_tuser   (tx_b_tuser),
      .out_tvalid   (out_tvalid),
      .out_tready   (out_tready),
      .out_tdata    (out_tdata),
      .out_tkeep    (out_tkeep),
      .out_tlast    (out_tlast),
      .out_tuser    (out_tuser),
      .commit_tvalid(commit_tvalid),
      .commit_tready(commit_tready),
      .commit_tdata (commit_tdata),
      .commit_tkeep (commit_tkeep),
      .commit_tlast (commit_tlast)
   );

   // Inputs only change 1 time unit after posedge, so a handshake seen at
   // negedge is the one that completes on the following posedge.
   always @(negedge clk) begin
      if (out_tvalid && out_tready)       out_q.push_back({out_tlast, out_tdata[63:48]});
      if (commit_tvalid && commit_tready) commit_q.push_back(commit_tdata[79:0]);
   end

   function automatic logic [TDW-1:0] mk_beat(input logic [7:0] fmt, input logic [9:0] tag,
                                              input logic [15:0] id);
      logic [TDW-1:0] d;
      d        = '0;
      d[31:24] = fmt;
      d[23]    = tag[9];
      d[19]    = tag[8];
      d[47:40] = tag[7:0];
      d[63:48] = id;
      return d;
   endfunction

   function automatic logic [79:0] exp_commit(input logic [9:0] tag);
      logic [79:0] v;
      v        = '0;
      v[31:24] = 8'h0A;
      v[23]    = tag[9];
      v[19]    = tag[8];
      v[79:72] = tag[7:0];
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic a_beat(input logic [TDW-1:0] d, input logic last, input string nm);
      bit got;
      got = 1'b0;
      tx_a_tvalid = 1'b1;
      tx_a_tdata  = d;
      tx_a_tlast  = last;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk);
         got = (tx_a_tready === 1'b1);
         @(posedge clk);
         #1;
      end
      tx_a_tvalid = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s: tx_a_tready actual 0 within 100 cycles, required 1", nm);
      end
   endtask

   task automatic b_beat(input logic [TDW-1:0] d, input logic last, input string nm);
      bit got;
      got = 1'b0;
      tx_b_tvalid = 1'b1;
      tx_b_tdata  = d;
      tx_b_tlast  = last;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk);
         got = (tx_b_tready === 1'b1);
         @(posedge clk);
         #1;
      end
      tx_b_tvalid = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s: tx_b_tready actual 0 within 100 cycles, required 1", nm);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tx_a_tvalid = 1'b1; tx_b_tvalid = 1'b1; out_tready = 1'b1; commit_tready = 1'b1;
      tx_a_tdata = mk_beat(8'h40, 10'h3FF, 16'h0); tx_a_tlast = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (out_tvalid !== 1'b0)    begin errors++; $display("FAIL rst_out_tvalid: actual %b required 0", out_tvalid); end
      checks++; if (tx_a_tready !== 1'b0)   begin errors++; $display("FAIL rst_a_tready: actual %b required 0", tx_a_tready); end
      checks++; if (tx_b_tready !== 1'b0)   begin errors++; $display("FAIL rst_b_tready: actual %b required 0", tx_b_tready); end
      checks++; if (commit_tvalid !== 1'b0) begin errors++; $display("FAIL rst_commit_tvalid: actual %b required 0", commit_tvalid); end
      tx_a_tvalid = 1'b0; tx_b_tvalid = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      @(negedge clk);
      checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL idle_out_tvalid: actual %b required 0", out_tvalid); end
      cyc();
   endtask

   task automatic test_contention();
      logic [16:0] exp;
      int p;
      out_q.delete(); commit_q.delete();
      out_tready = 1'b1; commit_tready = 1'b1;
      fork
         for (int pk = 0; pk < 2; pk++)
            for (int b = 0; b < 3; b++)
               a_beat(mk_beat((pk == 0) ? 8'h00 : 8'h20, 10'h1A0, {4'hA, 4'(pk), 8'(b)}), b == 2, "cont_a");
         for (int pk = 0; pk < 2; pk++)
            for (int b = 0; b < 3; b++)
               b_beat(mk_beat(8'h20, 10'h0B0, {4'hB, 4'(pk), 8'(b)}), b == 2, "cont_b");
      join
      repeat (3) cyc();
      checks++; if (out_q.size() != 12) begin errors++; $display("FAIL cont_beats: actual %0d required 12", out_q.size()); end
      for (int i = 0; i < 12 && i < out_q.size(); i++) begin
         p   = i / 3;
         exp = {(i % 3) == 2, (p % 2 == 0) ? 4'hA : 4'hB, 4'(p / 2), 8'(i % 3)};
         checks++;
         if (out_q[i] !== exp) begin errors++; $display("FAIL cont_order[%0d]: actual %h required %h", i, out_q[i], exp); end
      end
      checks++; if (commit_q.size() != 0) begin errors++; $display("FAIL cont_no_commit: actual %0d required 0", commit_q.size()); end
   endtask

   task automatic test_single_write();
      logic [TDW-1:0]   d, e;
      logic [TDW/8-1:0] k;
      out_q.delete(); commit_q.delete();
      out_tready = 1'b1; commit_tready = 1'b1;
      d = mk_beat(8'h40, 10'h155, 16'h5151);
      tx_a_tvalid = 1'b1; tx_a_tdata = d; tx_a_tlast = 1'b1;
      @(negedge clk);
      checks++; if (out_tvalid !== 1'b1)    begin errors++; $display("FAIL sw_out_tvalid: actual %b required 1", out_tvalid); end
      checks++; if (out_tdata !== d)        begin errors++; $display("FAIL sw_out_tdata: actual %h required %h", out_tdata[63:0], d[63:0]); end
      checks++; if (out_tlast !== 1'b1)     begin errors++; $display("FAIL sw_out_tlast: actual %b required 1", out_tlast); end
      checks++; if (commit_tvalid !== 1'b0) begin errors++; $display("FAIL sw_commit_early: actual %b required 0", commit_tvalid); end
      cyc();
      tx_a_tvalid = 1'b0;
      @(negedge clk);
      e = '0; e[31:24] = 8'h0A; e[79:72] = 8'h55; e[23] = 1'b0; e[19] = 1'b1;
      k = '0; k[31:0] = '1;
      checks++; if (commit_tvalid !== 1'b1)       begin errors++; $display("FAIL sw_commit_tvalid: actual %b required 1", commit_tvalid); end
      checks++; if (commit_tdata[31:24] !== 8'h0A) begin errors++; $display("FAIL sw_commit_type: actual %h required 0a", commit_tdata[31:24]); end
      checks++; if (commit_tdata[79:72] !== 8'h55) begin errors++; $display("FAIL sw_commit_tag: actual %h required 55", commit_tdata[79:72]); end
      checks++; if (commit_tdata !== e)           begin errors++; $display("FAIL sw_commit_tdata: actual %h required %h", commit_tdata[79:0], e[79:0]); end
      checks++; if (commit_tkeep !== k)           begin errors++; $display("FAIL sw_commit_tkeep: actual %h required %h", commit_tkeep, k); end
      checks++; if (commit_tlast !== 1'b1)        begin errors++; $display("FAIL sw_commit_tlast: actual %b required 1", commit_tlast); end
      cyc();
      @(negedge clk);
      checks++; if (commit_tvalid !== 1'b0) begin errors++; $display("FAIL sw_commit_once: actual %b required 0", commit_tvalid); end
      cyc();
   endtask

   task automatic test_commit_backpressure();
      out_q.delete(); commit_q.delete();
      out_tready = 1'b1; commit_tready = 1'b0;
      for (int i = 0; i < 8; i++)
         a_beat(mk_beat((i % 2 == 1) ? 8'h60 : 8'h40, 10'h2A0 + 10'(i), {4'hC, 12'(i)}), 1'b1, "bp_write");
      tx_a_tvalid = 1'b1; tx_a_tdata = mk_beat(8'h40, 10'h2A8, 16'hC008); tx_a_tlast = 1'b1;
      b_beat(mk_beat(8'h20, 10'h011, 16'hB500), 1'b0, "bp_b");
      b_beat(mk_beat(8'h00, 10'h000, 16'hB501), 1'b1, "bp_b");
      @(negedge clk);
      checks++; if (tx_a_tready !== 1'b0) begin errors++; $display("FAIL bp_9th_blocked: actual %b required 0", tx_a_tready); end
      checks++; if (out_q.size() != 10)   begin errors++; $display("FAIL bp_beats: actual %0d required 10", out_q.size()); end
      for (int i = 0; i < 8 && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i] !== {1'b1, 4'hC, 12'(i)}) begin errors++; $display("FAIL bp_a_order[%0d]: actual %h required %h", i, out_q[i], {1'b1, 4'hC, 12'(i)}); end
      end
      if (out_q.size() == 10) begin
         checks++; if (out_q[8] !== 17'h0B500) begin errors++; $display("FAIL bp_b0: actual %h required 0b500", out_q[8]); end
         checks++; if (out_q[9] !== 17'h1B501) begin errors++; $display("FAIL bp_b1: actual %h required 1b501", out_q[9]); end
      end
      cyc();
      commit_tready = 1'b1;
      @(negedge clk);
      checks++; if (tx_a_tready !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle: actual %b required 0", tx_a_tready); end
      cyc();
      @(negedge clk);
      checks++; if (tx_a_tready !== 1'b1) begin errors++; $display("FAIL bp_after_pop: actual %b required 1", tx_a_tready); end
      cyc();
      tx_a_tvalid = 1'b0;
      repeat (12) cyc();
      checks++; if (commit_q.size() != 9) begin errors++; $display("FAIL bp_commits: actual %0d required 9", commit_q.size()); end
      for (int i = 0; i < 9 && i < commit_q.size(); i++) begin
         checks++;
         if (commit_q[i] !== exp_commit(10'h2A0 + 10'(i))) begin errors++; $display("FAIL bp_commit_order[%0d]: actual %h required %h", i, commit_q[i], exp_commit(10'h2A0 + 10'(i))); end
      end
   endtask

   task automatic test_out_tready_toggle();
      out_q.delete(); commit_q.delete();
      out_tready = 1'b1; commit_tready = 1'b1;
      fork
         begin
            for (int k = 0; k < 16; k++) begin
               cyc();
               out_tready = ~out_tready;
            end
            out_tready = 1'b1;
         end
         for (int b = 0; b < 4; b++) begin
            b_beat(mk_beat((b == 0) ? 8'h20 : 8'h00, 10'h0AB, {8'hB7, 8'(b)}), b == 3, "tog_b");
            if (b == 1) repeat (2) cyc();
         end
         begin
            cyc();
            a_beat(mk_beat(8'h00, 10'h011, 16'hA700), 1'b1, "tog_a");
         end
      join
      repeat (2) cyc();
      checks++; if (out_q.size() != 5) begin errors++; $display("FAIL tog_beats: actual %0d required 5", out_q.size()); end
      for (int i = 0; i < 4 && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i] !== {i == 3, 8'hB7, 8'(i)}) begin errors++; $display("FAIL tog_b_order[%0d]: actual %h required %h", i, out_q[i], {i == 3, 8'hB7, 8'(i)}); end
      end
      if (out_q.size() == 5) begin
         checks++; if (out_q[4] !== 17'h1A700) begin errors++; $display("FAIL tog_a_after: actual %h required 1a700", out_q[4]); end
      end
   endtask

   task automatic test_reset_mid_packet();
      out_q.delete(); commit_q.delete();
      out_tready = 1'b1; commit_tready = 1'b1;
      a_beat(mk_beat(8'h60, 10'h3C3, 16'hA800), 1'b0, "rmp_beat");
      a_beat(mk_beat(8'h00, 10'h000, 16'hA801), 1'b0, "rmp_beat");
      tx_a_tvalid = 1'b1; tx_a_tdata = mk_beat(8'h00, 10'h000, 16'hA802); tx_a_tlast = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_tvalid !== 1'b0)    begin errors++; $display("FAIL rmp_out_tvalid: actual %b required 0", out_tvalid); end
      checks++; if (tx_a_tready !== 1'b0)   begin errors++; $display("FAIL rmp_a_tready: actual %b required 0", tx_a_tready); end
      checks++; if (commit_tvalid !== 1'b0) begin errors++; $display("FAIL rmp_commit_tvalid: actual %b required 0", commit_tvalid); end
      tx_a_tvalid = 1'b0;
      cyc();
      rst_n = 1'b1;
      repeat (5) cyc();
      checks++; if (commit_q.size() != 0) begin errors++; $display("FAIL rmp_no_commit: actual %0d required 0", commit_q.size()); end
      a_beat(mk_beat(8'h40, 10'h0F0, 16'hA810), 1'b1, "rmp_next");
      repeat (4) cyc();
      checks++; if (commit_q.size() != 1) begin errors++; $display("FAIL rmp_one_commit: actual %0d required 1", commit_q.size()); end
      if (commit_q.size() == 1) begin
         checks++; if (commit_q[0] !== exp_commit(10'h0F0)) begin errors++; $display("FAIL rmp_commit_tag: actual %h required %h", commit_q[0], exp_commit(10'h0F0)); end
      end
   endtask

   task automatic test_push_pop_full();
      logic [9:0] tags [10];
      bit acc;
      out_q.delete(); commit_q.delete();
      out_tready = 1'b1; commit_tready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tags[i] = 10'h301 + 10'(i);
         a_beat(mk_beat(8'h40, tags[i], {4'hD, 12'(i)}), 1'b1, "pp_fill");
      end
      tags[7] = 10'h1E7; tags[8] = 10'h0E8; tags[9] = 10'h2E9;
      // push of W7 and pop of the head complete on the same edge
      tx_a_tvalid = 1'b1; tx_a_tdata = mk_beat(8'h60, tags[7], 16'hD007); tx_a_tlast = 1'b1;
      commit_tready = 1'b1;
      @(negedge clk);
      checks++; if (tx_a_tready !== 1'b1)   begin errors++; $display("FAIL pp_push: actual %b required 1", tx_a_tready); end
      checks++; if (commit_tvalid !== 1'b1) begin errors++; $display("FAIL pp_pop: actual %b required 1", commit_tvalid); end
      cyc();
      commit_tready = 1'b0; tx_a_tvalid = 1'b0;
      a_beat(mk_beat(8'h40, tags[8], 16'hD008), 1'b1, "pp_eighth");
      tx_a_tvalid = 1'b1; tx_a_tdata = mk_beat(8'h40, tags[9], 16'hD009); tx_a_tlast = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (tx_a_tready !== 1'b0) begin errors++; $display("FAIL pp_full_block[%0d]: actual %b required 0", k, tx_a_tready); end
         cyc();
      end
      commit_tready = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 20 && !acc; c++) begin
         @(negedge clk);
         acc = (tx_a_tready === 1'b1);
         cyc();
      end
      tx_a_tvalid = 1'b0;
      checks++; if (!acc) begin errors++; $display("FAIL pp_ninth_accept: actual 0 within 20 cycles, required 1"); end
      repeat (14) cyc();
      checks++; if (commit_q.size() != 10) begin errors++; $display("FAIL pp_commits: actual %0d required 10", commit_q.size()); end
      for (int i = 0; i < 10 && i < commit_q.size(); i++) begin
         checks++;
         if (commit_q[i] !== exp_commit(tags[i])) begin errors++; $display("FAIL pp_order[%0d]: actual %h required %h", i, commit_q[i], exp_commit(tags[i])); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      tx_a_tvalid = 1'b0; tx_a_tdata = '0; tx_a_tkeep = '1; tx_a_tlast = 1'b0; tx_a_tuser = '0;
      tx_b_tvalid = 1'b0; tx_b_tdata = '0; tx_b_tkeep = '1; tx_b_tlast = 1'b0; tx_b_tuser = '0;
      out_tready = 1'b0; commit_tready = 1'b0;
      test_reset();
      test_contention();
      test_single_write();
      test_commit_backpressure();
      test_out_tready_toggle();
      test_reset_mid_packet();
      test_push_pop_full();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
